// File: rtl/resp_pkg.sv
// Shared response codes, fixed payloads, frame/decode types and serializer states.
// Defining RESP_CHECKSUM_EN makes frames four bytes with a trailing XOR checksum.
package resp_pkg;

  localparam logic [7:0] RESP_CODE_0 = 8'h01;
  localparam logic [7:0] RESP_CODE_1 = 8'h02;
  localparam logic [7:0] RESP_CODE_2 = 8'h03;
  localparam logic [7:0] RESP_CODE_3 = 8'h04;
  localparam logic [7:0] RESP_CODE_4 = 8'h05;
  localparam logic [7:0] RESP_CODE_5 = 8'h06;

  localparam logic [7:0] PAYLOAD_FIX_0 = 8'h80;
  localparam logic [7:0] PAYLOAD_FIX_1 = 8'hC0;
  localparam logic [7:0] PAYLOAD_FIX_4 = 8'hE0;
  localparam logic [7:0] PAYLOAD_FIX_5 = 8'hF0;

`ifdef RESP_CHECKSUM_EN
  localparam int FRAME_BYTES = 4;
`else
  localparam int FRAME_BYTES = 3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE, S_FINISH} ser_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] code;
    logic [7:0] payload;
    logic [2:0] ch;
  } frame_t;

  typedef struct packed {
    logic       ok;
    logic [7:0] code;
    logic [7:0] payload;
  } decode_t;

  function automatic decode_t decode_cmd(input logic [5:0] cmd, input logic [7:0] data);
    decode_t d;
    d = '{ok: 1'b1, code: 8'h00, payload: 8'h00};
    case (cmd)
      6'b000001: begin d.code = RESP_CODE_0; d.payload = PAYLOAD_FIX_0; end
      6'b000010: begin d.code = RESP_CODE_1; d.payload = PAYLOAD_FIX_1; end
      6'b000100: begin d.code = RESP_CODE_2; d.payload = data;          end
      6'b001000: begin d.code = RESP_CODE_3; d.payload = data;          end
      6'b010000: begin d.code = RESP_CODE_4; d.payload = PAYLOAD_FIX_4; end
      6'b100000: begin d.code = RESP_CODE_5; d.payload = PAYLOAD_FIX_5; end
      default:   d.ok = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] frame_byte(input frame_t f, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = f.addr;
      2'd1:    b = f.code;
      2'd2:    b = f.payload;
`ifdef RESP_CHECKSUM_EN
      default: b = f.addr ^ f.code ^ f.payload;
`else
      default: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous frame FIFO; an extra wrap bit on each pointer separates full from empty.
module resp_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage is not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/response_framer.sv
// Response framer: round-robin request arbiter, command decode into resp_fifo, byte serializer.
// Build macro RESP_CHECKSUM_EN appends an XOR checksum byte to every frame.
module response_framer
  import resp_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TX_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req_valid,
  output logic [N_CH-1:0]   req_ready,
  input  logic [6*N_CH-1:0] req_cmd,
  input  logic [8*N_CH-1:0] req_addr,
  input  logic [8*N_CH-1:0] req_data,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              frame_done,
  output logic [2:0]        frame_ch,
  output logic              err_pulse,
  output logic [7:0]        err_cnt
);
  localparam int TO_W = $clog2(TX_TIMEOUT + 1);

  ser_state_t      r_state;
  frame_t          r_frame;
  frame_t          w_fifo_in;
  frame_t          w_fifo_out;
  decode_t         w_dec;
  logic [1:0]      r_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic [2:0]      r_ptr;
  logic            r_run;
  logic            r_tx_start;
  logic [7:0]      r_tx_byte;
  logic            r_frame_done;
  logic [2:0]      r_frame_ch;
  logic            r_err_pulse;
  logic [7:0]      r_err_cnt;
  logic            w_found;
  logic [2:0]      w_gnt;
  logic [5:0]      w_cmd;
  logic [7:0]      w_addr;
  logic [7:0]      w_data;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_bad;
  logic            w_abort;
  logic [8:0]      w_err_sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cmd   = '0;
    w_addr  = '0;
    w_data  = '0;
    // First pass covers channels from the pointer upward, second pass wraps to the low ones.
    for (int c = 0; c < N_CH; c++) begin
      if (!w_found && req_valid[c] && (3'(c) >= r_ptr)) begin
        w_found = 1'b1;
        w_gnt   = 3'(c);
        w_cmd   = req_cmd[6*c +: 6];
        w_addr  = req_addr[8*c +: 8];
        w_data  = req_data[8*c +: 8];
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (!w_found && req_valid[c]) begin
        w_found = 1'b1;
        w_gnt   = 3'(c);
        w_cmd   = req_cmd[6*c +: 6];
        w_addr  = req_addr[8*c +: 8];
        w_data  = req_data[8*c +: 8];
      end
    end
  end

  // r_run keeps req_ready low during the first cycle after reset.
  assign req_ready = (w_found && r_run && !rst && !w_full) ? (N_CH'(1) << w_gnt) : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_dec     = decode_cmd(w_cmd, w_data);
  assign w_push    = w_accept && w_dec.ok;
  assign w_bad     = w_accept && !w_dec.ok;
  assign w_fifo_in = '{addr: w_addr, code: w_dec.code, payload: w_dec.payload, ch: w_gnt};
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_abort   = (r_state == S_SEND) && !tx_busy && (r_to_cnt == TO_W'(TX_TIMEOUT));
  assign w_err_sum = {1'b0, r_err_cnt} + 9'(w_bad) + 9'(w_abort);

  resp_fifo #(
    .WIDTH($bits(frame_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (w_fifo_in),
    .i_pop  (w_pop),
    .o_data (w_fifo_out),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_frame      <= '0;
      r_idx        <= '0;
      r_to_cnt     <= '0;
      r_ptr        <= '0;
      r_run        <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_byte    <= '0;
      r_frame_done <= 1'b0;
      r_frame_ch   <= '0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_run        <= 1'b1;
      r_frame_done <= 1'b0;
      r_err_pulse  <= w_bad || w_abort;
      r_err_cnt    <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      if (w_accept) r_ptr <= (w_gnt == 3'(N_CH - 1)) ? 3'd0 : w_gnt + 3'd1;

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_frame    <= w_fifo_out;
            r_idx      <= '0;
            r_tx_byte  <= w_fifo_out.addr;
            r_tx_start <= 1'b1;
            r_to_cnt   <= '0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= S_WAIT_DONE;
          end else if (w_abort) begin
            r_tx_start <= 1'b0;
            r_to_cnt   <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            if (r_idx == 2'(FRAME_BYTES - 1)) begin
              r_frame_done <= 1'b1;
              r_frame_ch   <= r_frame.ch;
              r_state      <= S_FINISH;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_tx_byte  <= frame_byte(r_frame, r_idx + 2'd1);
              r_tx_start <= 1'b1;
              r_to_cnt   <= '0;
              r_state    <= S_SEND;
            end
          end
        end
        S_FINISH: begin
          r_frame_ch <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_start   = r_tx_start;
  assign tx_byte    = r_tx_byte;
  assign frame_done = r_frame_done;
  assign frame_ch   = r_frame_ch;
  assign err_pulse  = r_err_pulse;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_response_framer.sv
// Directed self-checking bench for response_framer with a simple handshaking transmitter model.
`timescale 1ns/1ps
module tb_response_framer;
  localparam int N_CH       = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TX_TIMEOUT = 1023;
`ifdef RESP_CHECKSUM_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_CH-1:0]   req_valid = '0;
  logic [N_CH-1:0]   req_ready;
  logic [6*N_CH-1:0] req_cmd = '0;
  logic [8*N_CH-1:0] req_addr = '0;
  logic [8*N_CH-1:0] req_data = '0;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic              tx_busy = 1'b0;
  logic              tx_done = 1'b0;
  logic              frame_done;
  logic [2:0]        frame_ch;
  logic              err_pulse;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit         tx_en = 1'b1;
  int         tx_phase = 0;
  logic [7:0] tx_q[$];
  logic [2:0] fd_q[$];
  int         err_seen = 0;
  int         run_len = 0;
  int         max_run = 0;

  always #5 clk = ~clk;

  response_framer #(
    .N_CH(N_CH), .FIFO_DEPTH(FIFO_DEPTH), .TX_TIMEOUT(TX_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy), .tx_done(tx_done),
    .frame_done(frame_done), .frame_ch(frame_ch),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  // Transmitter model: busy one cycle after seeing tx_start, done pulse two cycles later.
  always @(negedge clk) begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    if (rst) tx_phase = 0;
    else if (tx_en) begin
      case (tx_phase)
        0: if (tx_start) begin tx_q.push_back(tx_byte); tx_busy = 1'b1; tx_phase = 1; end
        1: tx_phase = 2;
        default: begin tx_done = 1'b1; tx_phase = 0; end
      endcase
    end
    if (frame_done) fd_q.push_back(frame_ch);
    if (err_pulse) err_seen++;
    if (tx_start) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else run_len = 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic ch, input logic v, input logic [5:0] cmd,
                         input logic [7:0] addr, input logic [7:0] data);
    req_valid[ch] = v;
    if (ch) begin
      req_cmd[11:6] = cmd; req_addr[15:8] = addr; req_data[15:8] = data;
    end else begin
      req_cmd[5:0] = cmd; req_addr[7:0] = addr; req_data[7:0] = data;
    end
  endtask

  task automatic send(input logic ch, input logic [5:0] cmd, input logic [7:0] addr,
                      input logic [7:0] data);
    int waited = 0;
    set_req(ch, 1'b1, cmd, addr, data);
    #1;
    while (!req_ready[ch] && waited < 3000) begin
      @(negedge clk); #1; waited++;
    end
    check("accept", {31'b0, req_ready[ch]}, 32'd1);
    @(negedge clk);
    set_req(ch, 1'b0, 6'b0, 8'h00, 8'h00);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (fd_q.size() < n && c < budget) begin @(negedge clk); c++; end
    check("frame_count", fd_q.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    tx_q.delete(); fd_q.delete(); err_seen = 0; max_run = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int starts;

    // Reset: request pending throughout, all outputs must stay 0 during and just after reset.
    set_req(1'b0, 1'b1, 6'b000100, 8'h31, 8'h2A);
    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready, tx_start, tx_byte, frame_done, frame_ch, err_pulse, err_cnt}, 0);
    rst = 1'b0; #1;
    check("post_reset_outputs", {req_ready, tx_start, tx_byte, frame_done, frame_ch, err_pulse, err_cnt}, 0);

    // Basic frame and N+2 latency.
    @(negedge clk); #1;
    check("first_ready", req_ready, 2'b01);
    @(negedge clk);
    set_req(1'b0, 1'b0, 6'b0, 8'h00, 8'h00);
    check("latency_n1", tx_start, 0);
    @(negedge clk);
    check("latency_n2", tx_start, 1);
    check("first_byte", tx_byte, 8'h31);
    wait_frames(1, 200);
    check("f1_len", tx_q.size(), FB);
    check("f1_b0", tx_q[0], 8'h31);
    check("f1_b1", tx_q[1], 8'h03);
    check("f1_b2", tx_q[2], 8'h2A);
`ifdef RESP_CHECKSUM_EN
    check("f1_b3", tx_q[3], 8'h18);
`endif
    check("f1_ch", fd_q[0], 0);
    check("f1_no_err", err_seen, 0);

    // Round-robin tie.
    do_reset();
    clear_logs();
    set_req(1'b0, 1'b1, 6'b000001, 8'h41, 8'h00);
    set_req(1'b1, 1'b1, 6'b000001, 8'h42, 8'h00);
    #1;
    check("tie1_ready", req_ready, 2'b01);
    @(negedge clk); #1;
    check("tie2_ready", req_ready, 2'b10);
    @(negedge clk);
    set_req(1'b0, 1'b0, 6'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 6'b0, 8'h00, 8'h00);
    wait_frames(2, 400);
    check("tie_ch_a", fd_q[0], 0);
    check("tie_ch_b", fd_q[1], 1);
    check("tie_a_addr", tx_q[0], 8'h41);
    check("tie_a_code", tx_q[1], 8'h01);
    check("tie_a_pay", tx_q[2], 8'h80);
    check("tie_b_addr", tx_q[FB], 8'h42);

    // Invalid commands and error-count saturation.
    clear_logs();
    set_req(1'b0, 1'b1, 6'b000011, 8'h33, 8'h00);
    #1;
    check("bad_ready", req_ready, 2'b01);
    @(negedge clk);
    set_req(1'b0, 1'b0, 6'b0, 8'h00, 8'h00);
    check("bad_pulse", err_pulse, 1);
    check("bad_cnt", err_cnt, 1);
    repeat (10) @(negedge clk);
    check("bad_no_frame", fd_q.size(), 0);
    check("bad_no_bytes", tx_q.size(), 0);
    check("bad_pulses", err_seen, 1);
    set_req(1'b0, 1'b1, 6'b000000, 8'h33, 8'h00);
    repeat (299) @(negedge clk);
    set_req(1'b0, 1'b0, 6'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("sat_cnt", err_cnt, 8'd255);
    check("sat_pulses", err_seen, 300);

    // Transmit timeout, then the next queued frame goes out normally.
    do_reset();
    clear_logs();
    tx_en = 1'b0;
    send(1'b0, 6'b000010, 8'h51, 8'h00);
    send(1'b1, 6'b100000, 8'h52, 8'h00);
    c = 0;
    while (!tx_start && c < 50) begin @(negedge clk); c++; end
    c = 0;
    while (tx_start && c < 1200) begin @(negedge clk); c++; end
    check("abort_drop", tx_start, 0);
    check("abort_pulse", err_pulse, 1);
    check("abort_no_done", frame_done, 0);
    tx_en = 1'b1;
    wait_frames(1, 400);
    check("abort_window", {31'b0, (max_run >= TX_TIMEOUT) && (max_run <= TX_TIMEOUT + 1)}, 1);
    check("after_abort_ch", fd_q[0], 1);
    check("after_abort_len", tx_q.size(), FB);
    check("after_abort_b0", tx_q[0], 8'h52);
    check("after_abort_b1", tx_q[1], 8'h06);
    check("after_abort_b2", tx_q[2], 8'hF0);
    check("abort_cnt", err_cnt, 1);
    check("abort_pulses", err_seen, 1);

    // FIFO full with the transmitter stalled.
    clear_logs();
    tx_en = 1'b0;
    for (int k = 0; k < FIFO_DEPTH + 1; k++) send(1'b0, 6'b010000, 8'h60 + 8'(k), 8'h00);
    set_req(1'b0, 1'b1, 6'b010000, 8'h65, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("full_ready_low", req_ready, 2'b00);
      @(negedge clk);
    end
    tx_en = 1'b1;
    send(1'b0, 6'b010000, 8'h65, 8'h00);
    wait_frames(FIFO_DEPTH + 2, 2000);
    for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
      check("full_addr", tx_q[k*FB], 8'h60 + 8'(k));
      check("full_code", tx_q[k*FB+1], 8'h05);
    end

    // Reset in the middle of a frame.
    clear_logs();
    send(1'b0, 6'b000100, 8'h70, 8'h11);
    c = 0;
    while (tx_q.size() < 3 && c < 200) begin @(negedge clk); c++; end
    check("mid_bytes", tx_q.size(), 3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_start", tx_start, 0);
    check("mid_rst_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    starts = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    check("mid_no_restart", starts, 0);
    check("mid_no_frame", fd_q.size(), 0);
    check("mid_err_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
